// File: rtl/irq_controller.sv
// irq_controller: external-interrupt controller between NCHAN request lines
// and the CPU i_irq/o_iack pair. It latches edge requests, follows level
// requests, applies a per-channel mask, and presents a snapshot word on
// o_data during acknowledge, followed by a HOLDOFF-cycle quiet window.
//
// Optional feature macro: IRQ_PRIO_EN
//   defined   - each ack reports only the lowest-numbered masked pending
//               channel (one-hot o_data, index on o_vector).
//   undefined - each ack reports the whole masked pending word, o_vector = 0.
//
// Handshake: o_irq is a level request. The CPU raises i_iack and holds it for
// one or more cycles. o_data is valid and stable from the cycle after i_iack
// is first seen until the next acknowledge begins. o_irq stays low during ACK
// and for HOLDOFF cycles after i_iack drops.
module irq_controller #(
    parameter int NCHAN   = 64,
    parameter int HOLDOFF = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [NCHAN-1:0] i_req,
    input  logic        i_iack,
    input  logic        i_mask_wr,
    input  logic        i_mode_wr,
    input  logic [63:0] i_wdata,
    output logic        o_irq,
    output logic [63:0] o_data,
    output logic [5:0]  o_vector,
    output logic [63:0] o_pending,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NCHAN-1:0] pending_q, pending_d;
    logic [NCHAN-1:0] mask_q, mask_d;
    logic [NCHAN-1:0] mode_q, mode_d;
    logic [NCHAN-1:0] req_prev_q, req_prev_d;
    logic             irq_q, irq_d;
    logic [63:0]      data_q, data_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [NCHAN-1:0] rise;
    logic [NCHAN-1:0] active;
    logic [NCHAN-1:0] snap;
    logic [NCHAN-1:0] clr;

`ifdef IRQ_PRIO_EN
    logic [5:0]       vector_q, vector_d;
    logic [5:0]       snap_idx;
    logic             found;
`endif

    // Snapshot selection: either the full masked word or its lowest set bit.
    always_comb begin
        active = pending_q & mask_q;
`ifdef IRQ_PRIO_EN
        snap     = '0;
        snap_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (active[i] && !found) begin
                snap[i]  = 1'b1;
                snap_idx = 6'(i);
                found    = 1'b1;
            end
        end
`else
        snap = active;
`endif
    end

    // Next-state logic: FSM, pending update, config registers, irq output.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        clr        = '0;
        rise       = i_req & ~req_prev_q;
        req_prev_d = i_req;
        mask_d     = i_mask_wr ? i_wdata[NCHAN-1:0] : mask_q;
        mode_d     = i_mode_wr ? i_wdata[NCHAN-1:0] : mode_q;
`ifdef IRQ_PRIO_EN
        vector_d   = vector_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (i_iack) begin
                    state_d = ST_ACK;
                    data_d  = 64'(snap);
                    // Level bits simply follow i_req, so only edge bits clear.
                    clr     = snap & ~mode_q;
`ifdef IRQ_PRIO_EN
                    vector_d = snap_idx;
`endif
                end
            end
            ST_ACK: begin
                if (!i_iack) begin
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = 8'(HOLDOFF);
                    end
                end
            end
            ST_HOLD: begin
                // HOLD lasts exactly HOLDOFF cycles.
                cnt_d = cnt_q - 8'd1;
                if (cnt_d == 8'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A fresh edge beats a clear in the same cycle, so it is not lost.
        pending_d = (((pending_q & ~clr) | rise) & ~mode_q) | (i_req & mode_q);
        irq_d     = (state_d == ST_IDLE) && (|active);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            mask_q     <= '1;
            mode_q     <= '0;
            req_prev_q <= '0;
            irq_q      <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
`ifdef IRQ_PRIO_EN
            vector_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            req_prev_q <= req_prev_d;
            irq_q      <= irq_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
`ifdef IRQ_PRIO_EN
            vector_q   <= vector_d;
`endif
        end
    end

    assign o_irq     = irq_q;
    assign o_data    = data_q;
    assign o_pending = 64'(pending_q);
    assign o_state   = state_q;
`ifdef IRQ_PRIO_EN
    assign o_vector  = vector_q;
`else
    assign o_vector  = 6'd0;
`endif

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller with hand-computed expectations.
module tb_irq_controller;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACK  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [63:0] ONES  = 64'hffff_ffff_ffff_ffff;

    logic        clk;
    logic        reset;
    logic [63:0] i_req;
    logic        i_iack;
    logic        i_mask_wr;
    logic        i_mode_wr;
    logic [63:0] i_wdata;
    logic        o_irq;
    logic [63:0] o_data;
    logic [5:0]  o_vector;
    logic [63:0] o_pending;
    logic [1:0]  o_state;

    int n_tests;
    int n_fail;

    irq_controller #(.NCHAN(64), .HOLDOFF(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_iack    (i_iack),
        .i_mask_wr (i_mask_wr),
        .i_mode_wr (i_mode_wr),
        .i_wdata   (i_wdata),
        .o_irq     (o_irq),
        .o_data    (o_data),
        .o_vector  (o_vector),
        .o_pending (o_pending),
        .o_state   (o_state)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [63:0] v);
        i_mask_wr = 1'b1;
        i_wdata   = v;
        tick();
        i_mask_wr = 1'b0;
        i_wdata   = '0;
    endtask

    task automatic write_mode(input logic [63:0] v);
        i_mode_wr = 1'b1;
        i_wdata   = v;
        tick();
        i_mode_wr = 1'b0;
        i_wdata   = '0;
    endtask

    // One-cycle edge pulse on the given channels, then idle.
    task automatic pulse(input logic [63:0] v);
        i_req = v;
        tick();
        i_req = '0;
    endtask

    // Drop i_iack after the ack cycle and run through ACK + 2 HOLD cycles.
    task automatic finish_ack();
        i_iack = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        i_req     = '0;
        i_iack    = 1'b0;
        i_mask_wr = 1'b0;
        i_mode_wr = 1'b0;
        i_wdata   = '0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_irq",     {63'd0, o_irq}, 64'd0);
        check("rst_data",    o_data, 64'd0);
        check("rst_pending", o_pending, 64'd0);
        check("rst_vector",  {58'd0, o_vector}, 64'd0);
        check("rst_state",   {62'd0, o_state}, {62'd0, S_IDLE});

`ifndef IRQ_PRIO_EN
        // 1: edge pulses 0xa5, two-cycle latency, full-word ack, hold window.
        pulse(64'ha5);
        check("t1_pend",      o_pending, 64'ha5);
        check("t1_irq_lat1",  {63'd0, o_irq}, 64'd0);
        tick();
        check("t1_irq_lat2",  {63'd0, o_irq}, 64'd1);
        i_iack = 1'b1;
        tick();
        check("t1_data",      o_data, 64'ha5);
        check("t1_pend_clr",  o_pending, 64'd0);
        check("t1_irq_ack",   {63'd0, o_irq}, 64'd0);
        check("t1_state_ack", {62'd0, o_state}, {62'd0, S_ACK});
        check("t1_vector",    {58'd0, o_vector}, 64'd0);
        i_iack = 1'b0;
        tick();
        check("t1_state_hold", {62'd0, o_state}, {62'd0, S_HOLD});
        check("t1_irq_hold1",  {63'd0, o_irq}, 64'd0);
        i_iack = 1'b1;   // ignored in HOLD
        tick();
        check("t1_irq_hold2",  {63'd0, o_irq}, 64'd0);
        check("t1_data_hold",  o_data, 64'ha5);
        i_iack = 1'b0;
        tick();
        check("t1_state_idle", {62'd0, o_state}, {62'd0, S_IDLE});
        check("t1_irq_after",  {63'd0, o_irq}, 64'd0);

        // 2: masking hides but keeps pending bits; unmasking re-raises o_irq.
        write_mask(64'h0f);
        pulse(64'ha5);
        tick();
        check("t2_irq",       {63'd0, o_irq}, 64'd1);
        i_iack = 1'b1;
        tick();
        check("t2_data",      o_data, 64'h05);
        check("t2_pend",      o_pending, 64'ha0);
        finish_ack();
        check("t2_irq_masked", {63'd0, o_irq}, 64'd0);
        check("t2_pend_kept",  o_pending, 64'ha0);
        write_mask(ONES);
        tick();
        check("t2_irq_unmask", {63'd0, o_irq}, 64'd1);
        i_iack = 1'b1;
        tick();
        check("t2_data2",     o_data, 64'ha0);
        finish_ack();
        check("t2_pend_empty", o_pending, 64'd0);

        // 3: level channel 3 held across ack, then released.
        write_mode(64'h08);
        i_req = 64'h08;
        tick();
        tick();
        check("t3_irq",       {63'd0, o_irq}, 64'd1);
        i_iack = 1'b1;
        tick();
        check("t3_data",      o_data, 64'h08);
        check("t3_pend_lvl",  o_pending, 64'h08);
        finish_ack();
        check("t3_irq_again", {63'd0, o_irq}, 64'd1);
        i_req = '0;
        tick();
        tick();
        check("t3_irq_drop",  {63'd0, o_irq}, 64'd0);
        check("t3_pend_drop", o_pending, 64'd0);
        write_mode(64'd0);

        // 4: new ch1 edge in the snapshot cycle survives the clear.
        pulse(64'h02);
        tick();
        i_req  = 64'h02;
        i_iack = 1'b1;
        tick();
        i_req  = '0;
        check("t4_data",      o_data, 64'h02);
        check("t4_pend_set",  o_pending, 64'h02);
        finish_ack();
        check("t4_irq",       {63'd0, o_irq}, 64'd1);
        i_iack = 1'b1;
        tick();
        check("t4_data2",     o_data, 64'h02);
        check("t4_pend_clr",  o_pending, 64'd0);
        finish_ack();

        // Ack with nothing pending: empty snapshot, normal sequence.
        i_iack = 1'b1;
        tick();
        check("empty_data",   o_data, 64'd0);
        check("empty_state",  {62'd0, o_state}, {62'd0, S_ACK});
        finish_ack();
        check("empty_idle",   {62'd0, o_state}, {62'd0, S_IDLE});

        // Edge -> level switch discards a latched edge bit.
        pulse(64'h10);
        tick();
        check("mode_pend_latched", o_pending, 64'h10);
        write_mode(64'h10);
        tick();
        check("mode_pend_dropped", o_pending, 64'd0);
        write_mode(64'd0);
        tick();
        check("mode_irq_low", {63'd0, o_irq}, 64'd0);

        // 5: reset during HOLD returns everything to reset values.
        write_mask(64'h0f);
        pulse(64'h31);
        tick();
        i_iack = 1'b1;
        tick();
        check("t5_data",      o_data, 64'h01);
        check("t5_pend",      o_pending, 64'h30);
        i_iack = 1'b0;
        tick();
        check("t5_state_hold", {62'd0, o_state}, {62'd0, S_HOLD});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_irq",       {63'd0, o_irq}, 64'd0);
        check("t5_data_rst",  o_data, 64'd0);
        check("t5_pend_rst",  o_pending, 64'd0);
        check("t5_state",     {62'd0, o_state}, {62'd0, S_IDLE});
        pulse(64'h30);
        tick();
        check("t5_mask_ones", {63'd0, o_irq}, 64'd1);
        i_iack = 1'b1;
        tick();
        check("t5_data_post", o_data, 64'h30);
        finish_ack();
`else
        // 6: priority mode reports one channel per ack, lowest first.
        begin
            logic [63:0] exp_data [4];
            logic [5:0]  exp_vec  [4];
            exp_data[0] = 64'h01; exp_vec[0] = 6'd0;
            exp_data[1] = 64'h04; exp_vec[1] = 6'd2;
            exp_data[2] = 64'h20; exp_vec[2] = 6'd5;
            exp_data[3] = 64'h80; exp_vec[3] = 6'd7;
            pulse(64'ha5);
            tick();
            for (int k = 0; k < 4; k++) begin
                check($sformatf("t6_irq_%0d", k), {63'd0, o_irq}, 64'd1);
                i_iack = 1'b1;
                tick();
                check($sformatf("t6_data_%0d", k), o_data, exp_data[k]);
                check($sformatf("t6_vec_%0d", k), {58'd0, o_vector}, {58'd0, exp_vec[k]});
                finish_ack();
            end
            check("t6_irq_done",  {63'd0, o_irq}, 64'd0);
            check("t6_pend_done", o_pending, 64'd0);
            tick();
            check("t6_irq_stays", {63'd0, o_irq}, 64'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
